// File: rtl/fifo_pkg.sv
// Shared pointer definitions and Gray-code helpers for both sides of the async FIFO.
// Pointers carry one extra wrap bit above the RAM address.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int PTR_WIDTH       = FIFO_ADDR_WIDTH + 1;

    typedef logic [PTR_WIDTH-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[PTR_WIDTH-1] = gray[PTR_WIDTH-1];
        for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray_ptr.sv
// Binary and Gray pointer pair with increment enable; the next-state values are
// exported so callers can compute flags for the coming edge without extra latency.
module fifo_gray_ptr
    import fifo_pkg::*;
#(
    parameter int PTR_W = PTR_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] bin_o,
    output logic [PTR_W-1:0] bin_next_o,
    output logic [PTR_W-1:0] gray_o,
    output logic [PTR_W-1:0] gray_next_o
);

    logic [PTR_W-1:0] bin_q;
    logic [PTR_W-1:0] gray_q;
    logic [PTR_W-1:0] bin_d;
    logic [PTR_W-1:0] gray_d;

    always_comb begin
        bin_d  = bin_q + PTR_W'(inc_i);
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin_o       = bin_q;
    assign bin_next_o  = bin_d;
    assign gray_o      = gray_q;
    assign gray_next_o = gray_d;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: read pointer, empty/level flags and a
// registered first-word-fall-through output stage with valid/ready handshake.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int RAM_DEPTH  = 16
) (
    input  logic                  RCLK,
    input  logic                  RRST,
    input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata_ram,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  rempty,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    logic                  pop;
    logic [PTR_W-1:0]      rbin;
    logic [PTR_W-1:0]      rbinNext;
    logic [PTR_W-1:0]      rgray;
    logic [PTR_W-1:0]      rgrayNext;
    logic [PTR_W-1:0]      wbinSync;
    logic                  unusedRbinMsb;

    logic                  rempty_q, rempty_d;
    logic [PTR_W-1:0]      rlevel_q, rlevel_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  doutValid_q, doutValid_d;

    // A word leaves the RAM whenever one is available and the output slot is free or being emptied.
    assign pop = !rempty_q && (!doutValid_q || dout_ready);

    fifo_gray_ptr #(
        .PTR_W(PTR_W)
    ) u_rptr (
        .clk_i      (RCLK),
        .rst_i      (RRST),
        .inc_i      (pop),
        .bin_o      (rbin),
        .bin_next_o (rbinNext),
        .gray_o     (rgray),
        .gray_next_o(rgrayNext)
    );

    assign wbinSync = gray2bin(wptr_gray_sync);

    // Flags look at the post-edge pointer so the last pop raises empty in the same edge.
    always_comb begin
        rempty_d    = (rgrayNext == wptr_gray_sync);
        rlevel_d    = wbinSync - rbinNext;
        dout_d      = dout_q;
        doutValid_d = doutValid_q;
        if (pop) begin
            dout_d      = rdata_ram;
            doutValid_d = 1'b1;
        end else if (dout_ready) begin
            doutValid_d = 1'b0;
        end
    end

    always_ff @(posedge RCLK) begin
        if (RRST) begin
            rempty_q    <= 1'b1;
            rlevel_q    <= '0;
            dout_q      <= '0;
            doutValid_q <= 1'b0;
        end else begin
            rempty_q    <= rempty_d;
            rlevel_q    <= rlevel_d;
            dout_q      <= dout_d;
            doutValid_q <= doutValid_d;
        end
    end

    // The wrap bit only matters for full/empty distinction, never for addressing.
    assign unusedRbinMsb = rbin[ADDR_WIDTH];

    assign raddr      = rbin[ADDR_WIDTH-1:0];
    assign rptr_gray  = rgray;
    assign rempty     = rempty_q;
    assign rlevel     = rlevel_q;
    assign dout       = dout_q;
    assign dout_valid = doutValid_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: a queue-based FIFO model drives expectations,
// with directed scenarios pinned by literal values followed by randomized traffic.
module tb_fifo_rd_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] wptrGray;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdataRam;
    logic [PW-1:0] rptrGray;
    logic          rempty;
    logic [PW-1:0] rlevel;
    logic [DW-1:0] dout;
    logic          doutValid;
    logic          doutReady;

    logic [DW-1:0] ram [DEPTH];

    int            vectors     = 0;
    int            miscompares = 0;

    int            wcnt;
    int            rcnt;
    logic [DW-1:0] pending [$];
    logic          mEmpty;
    int            mLevel;
    logic          mValid;
    logic [DW-1:0] mDout;
    logic [PW-1:0] prevGray;

    always #5 clk = ~clk;

    assign rdataRam = ram[raddr];

    fifo_rd_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RAM_DEPTH (DEPTH)
    ) dut (
        .RCLK          (clk),
        .RRST          (rst),
        .wptr_gray_sync(wptrGray),
        .raddr         (raddr),
        .rdata_ram     (rdataRam),
        .rptr_gray     (rptrGray),
        .rempty        (rempty),
        .rlevel        (rlevel),
        .dout          (dout),
        .dout_valid    (doutValid),
        .dout_ready    (doutReady)
    );

    function automatic logic [PW-1:0] grayOf(input int n);
        int m;
        m = n % 32;
        return PW'(m ^ (m >> 1));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Writer side: place a word in RAM and publish the advanced write pointer.
    task automatic pushWord(input logic [DW-1:0] d);
        ram[wcnt % DEPTH] = d;
        pending.push_back(d);
        wcnt++;
        wptrGray = grayOf(wcnt);
    endtask

    // Drive one cycle of inputs and advance the model to its post-edge state.
    task automatic applyStimulus(input bit rstV, input bit rdy);
        bit doPop;
        @(negedge clk);
        rst       = rstV;
        doutReady = rdy;
        if (rstV) begin
            wcnt     = 0;
            rcnt     = 0;
            wptrGray = '0;
            pending.delete();
            mEmpty   = 1'b1;
            mLevel   = 0;
            mValid   = 1'b0;
            mDout    = '0;
        end else begin
            doPop = !mEmpty && (!mValid || rdy);
            if (doPop) begin
                mDout  = pending.pop_front();
                mValid = 1'b1;
                rcnt++;
            end else if (rdy) begin
                mValid = 1'b0;
            end
            mEmpty = (pending.size() == 0);
            mLevel = pending.size();
        end
        @(posedge clk);
        #2;
    endtask

    // Every cycle the DUT outputs must agree with the model.
    always @(posedge clk) begin
        #1;
        checkOutput("rempty", 32'(rempty), 32'(mEmpty));
        checkOutput("rlevel", 32'(rlevel), 32'(mLevel));
        checkOutput("dout_valid", 32'(doutValid), 32'(mValid));
        checkOutput("dout", 32'(dout), 32'(mDout));
        checkOutput("raddr", 32'(raddr), 32'(rcnt % DEPTH));
        checkOutput("rptr_gray", 32'(rptrGray), 32'(grayOf(rcnt)));
        if (!rst && rptrGray !== prevGray) begin
            checkOutput("grayStep", 32'($countones(rptrGray ^ prevGray)), 32'd1);
        end
        prevGray = rptrGray;
    end

    initial begin
        int pushed;
        rst       = 1'b1;
        doutReady = 1'b0;
        wptrGray  = '0;
        wcnt      = 0;
        rcnt      = 0;
        mEmpty    = 1'b1;
        mLevel    = 0;
        mValid    = 1'b0;
        mDout     = '0;
        prevGray  = '0;
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;

        applyStimulus(1, 0);
        applyStimulus(1, 0);
        checkOutput("resetEmpty", 32'(rempty), 32'd1);
        checkOutput("resetValid", 32'(doutValid), 32'd0);
        checkOutput("resetRaddr", 32'(raddr), 32'd0);
        checkOutput("resetGray", 32'(rptrGray), 32'd0);
        checkOutput("resetLevel", 32'(rlevel), 32'd0);

        pushWord(8'hA5);
        applyStimulus(0, 1);
        checkOutput("singleEmptyK", 32'(rempty), 32'd0);
        checkOutput("singleValidK", 32'(doutValid), 32'd0);
        applyStimulus(0, 1);
        checkOutput("singleDout", 32'(dout), 32'hA5);
        checkOutput("singleValid", 32'(doutValid), 32'd1);
        checkOutput("singleEmpty", 32'(rempty), 32'd1);
        checkOutput("singleGray", 32'(rptrGray), 32'd1);
        checkOutput("singleRaddr", 32'(raddr), 32'd1);
        applyStimulus(0, 1);
        checkOutput("singleDrained", 32'(doutValid), 32'd0);

        applyStimulus(1, 0);
        pushWord(8'h11);
        pushWord(8'h22);
        pushWord(8'h33);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0);
        checkOutput("bpDout", 32'(dout), 32'h11);
        checkOutput("bpValid", 32'(doutValid), 32'd1);
        checkOutput("bpLevel", 32'(rlevel), 32'd2);
        checkOutput("bpRaddr", 32'(raddr), 32'd1);
        applyStimulus(0, 1);
        checkOutput("bpDout2", 32'(dout), 32'h22);
        applyStimulus(0, 1);
        checkOutput("bpDout3", 32'(dout), 32'h33);
        checkOutput("bpEmpty", 32'(rempty), 32'd1);
        applyStimulus(0, 1);
        checkOutput("bpDrained", 32'(doutValid), 32'd0);

        applyStimulus(1, 0);
        for (int i = 0; i < 16; i++) begin
            pushWord(DW'(i));
            applyStimulus(0, 1);
            checkOutput("streamLevelMax", 32'(rlevel <= 2), 32'd1);
            if (i >= 1) begin
                checkOutput("streamValid", 32'(doutValid), 32'd1);
                checkOutput("streamDout", 32'(dout), 32'(i - 1));
            end
        end
        applyStimulus(0, 1);
        checkOutput("streamLast", 32'(dout), 32'h0F);

        applyStimulus(1, 0);
        pushed = 0;
        for (int c = 0; c < 400 && (pushed < 40 || mValid || pending.size() != 0); c++) begin
            if (pushed < 40 && pending.size() < DEPTH && ($urandom % 4) != 0) begin
                pushWord(DW'(8'h40 + pushed));
                pushed++;
            end
            applyStimulus(0, ($urandom % 3) != 0);
        end
        checkOutput("wrapCount", 32'(rcnt), 32'd40);

        applyStimulus(1, 0);
        for (int i = 0; i < 6; i++) pushWord(DW'(8'hC0 + i));
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("preRstValid", 32'(doutValid), 32'd1);
        checkOutput("preRstLevel", 32'(rlevel), 32'd5);
        applyStimulus(1, 1);
        checkOutput("midRstValid", 32'(doutValid), 32'd0);
        checkOutput("midRstEmpty", 32'(rempty), 32'd1);
        checkOutput("midRstLevel", 32'(rlevel), 32'd0);
        checkOutput("midRstRaddr", 32'(raddr), 32'd0);
        checkOutput("midRstGray", 32'(rptrGray), 32'd0);
        checkOutput("midRstDout", 32'(dout), 32'd0);

        for (int c = 0; c < 800; c++) begin
            if ($urandom % 100 == 0) begin
                applyStimulus(1, 0);
            end else begin
                if (pending.size() < DEPTH && ($urandom % 2) != 0) pushWord(DW'($urandom));
                applyStimulus(0, ($urandom % 4) != 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side controller of the asynchronous FIFO, the reader counterpart to the dual-port RAM's write port.
- Owns the read pointer (binary and Gray) and drives the RAM read address.
- Computes empty and fill level from a write pointer already synchronized into the read domain.
- Presents data through a registered first-word-fall-through output stage with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8: word width; must match the RAM.
- ADDR_WIDTH, 4: RAM address width; pointers are ADDR_WIDTH+1 bits.
- RAM_DEPTH, 16: must equal 2**ADDR_WIDTH.

Ports:
- RCLK  input  1  read-domain clock
- RRST  input  1  synchronous, active-high reset
- wptr_gray_sync  input  ADDR_WIDTH+1  write Gray pointer, already double-flopped into RCLK
- raddr  output  ADDR_WIDTH  read address to RAM (asynchronous read)
- rdata_ram  input  DATA_WIDTH  RAM read data for raddr
- rptr_gray  output  ADDR_WIDTH+1  registered read Gray pointer, to the write-domain synchronizer
- rempty  output  1  registered; RAM holds no unread word
- rlevel  output  ADDR_WIDTH+1  registered count of words in RAM, excluding the output register
- dout  output  DATA_WIDTH  output data
- dout_valid  output  1  dout holds a word
- dout_ready  input  1  consumer accepts dout this cycle

Behaviour:
- Single clock RCLK; reset is synchronous and active-high on RRST.
- Reset values: rbin=0, rptr_gray=0, rempty=1, rlevel=0, dout=0, dout_valid=0. raddr therefore resets to 0.
- pop (combinational) = !rempty && (!dout_valid || dout_ready).
- rbin_next = rbin + pop, modulo 2**(ADDR_WIDTH+1). rgray_next = rbin_next ^ (rbin_next >> 1).
- Each edge: rbin <= rbin_next, rptr_gray <= rgray_next.
- rempty <= (rgray_next == wptr_gray_sync).
- rlevel <= gray2bin(wptr_gray_sync) - rbin_next, modulo 2**(ADDR_WIDTH+1); never exceeds RAM_DEPTH in legal operation.
- raddr = rbin[ADDR_WIDTH-1:0], driven straight from the register with no combinational path from inputs.
- Output stage:
  - On pop: dout <= rdata_ram, dout_valid <= 1.
  - Else if dout_ready: dout_valid <= 0.
  - Else: hold dout and dout_valid.
- Simultaneous accept and refill (dout_valid && dout_ready && !rempty): the word is replaced and dout_valid stays 1, giving full throughput of one word per cycle.
- dout_ready while dout_valid=0 has no effect.
- Latency: a wptr_gray_sync change seen before edge k gives rempty=0 after edge k, and dout_valid=1 after edge k+1.
- Empty boundary: the last word popped sets rempty=1 in the same edge, so no further pop occurs and there is no underflow.
- Wrap: rbin rolls from 2**(ADDR_WIDTH+1)-1 to 0. raddr wraps from RAM_DEPTH-1 to 0. The Gray code is continuous across the wrap.
- Full (rlevel=RAM_DEPTH) needs no special handling on this side; it is detected by the write side.
- Reset mid-operation: all state returns to its reset values in one edge, and any word held in dout is discarded. The write side must be reset in the same system reset sequence.
- rptr_gray changes at most one bit per edge.

Decomposition:
- Package fifo_pkg:
  - function bin2gray and function gray2bin, parameterized through a PTR_WIDTH = ADDR_WIDTH+1 constant.
  - Shared with the write-side controller.
- One sub-module is natural: fifo_gray_ptr.
  - Binary plus Gray pointer register with an increment enable.
  - Outputs bin, bin_next, gray, gray_next.
  - Reused by the write-side controller.
- The output stage and flags stay in fifo_rd_ctrl.

Test Plan:
- Reset: hold RRST for 2 cycles with wptr_gray_sync=0 -> rempty=1, dout_valid=0, raddr=0, rptr_gray=0, rlevel=0.
- Single word: RAM[0]=0xA5; step wptr_gray_sync 0->1 before edge k -> rempty=0 after edge k, dout=0xA5 and dout_valid=1 after edge k+1, then rempty=1, rptr_gray=1, raddr=1.
- Backpressure:
  - RAM[0..2]=0x11,0x22,0x33; wptr_gray_sync=bin2gray(3); dout_ready=0 -> dout holds 0x11 indefinitely, rlevel=2, raddr=1.
  - Raise dout_ready -> 0x22 and 0x33 on consecutive cycles, then dout_valid=0.
- Streaming: 16 words 0x00..0x0F, wptr advanced one per cycle, dout_ready=1 constantly -> dout sequence 0x00..0x0F, no gaps after the first word, rlevel never above 2.
- Wrap: push and drain 40 words -> rbin crosses 31->0, rptr_gray Hamming distance 1 on every change, data order preserved.
- Mid-stream reset: assert RRST with dout_valid=1 and rlevel=5 -> next cycle all outputs at reset values, no pop that cycle.
